// File: rtl/dac_spi_tx_if.sv
// Signal bundle between the DDS sample stream and the serial DAC driver.
// The master modport is the DDS/host side; the slave modport is the driver.
interface dac_spi_tx_if #(
    parameter int DATA_BIT = 12
);
    logic [DATA_BIT-1:0] dds_data;
    logic                dds_data_en;
    logic                dac_sclk;
    logic                dac_din;
    logic                dac_cs_n;
    logic                busy;
    logic                frame_done;

    modport master (
        output dds_data, dds_data_en,
        input  dac_sclk, dac_din, dac_cs_n, busy, frame_done
    );

    modport slave (
        input  dds_data, dds_data_en,
        output dac_sclk, dac_din, dac_cs_n, busy, frame_done
    );
endinterface

// File: rtl/dac_spi_tx.sv
// Serial DAC driver: decimates the DDS sample stream by capturing one sample when
// idle and shifting {CTRL_WORD, sample} out MSB first as an SPI mode-0 frame.
module dac_spi_tx #(
    parameter int                   DATA_BIT  = 12,
    parameter int                   CTRL_BITS = 4,
    parameter logic [CTRL_BITS-1:0] CTRL_WORD = '0,
    parameter int                   HALF_DIV  = 2,
    parameter int                   HOLD_CYC  = 2
) (
    input logic         sclk,
    input logic         rst,
    dac_spi_tx_if.slave bus
);
    localparam int F      = CTRL_BITS + DATA_BIT;
    localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BIT_W  = $clog2(F + 1);
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(F);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [F-1:0]       shift_q, shift_d;
    logic               dac_sclk_q, dac_sclk_d;
    logic               dac_din_q, dac_din_d;
    logic               dac_cs_n_q, dac_cs_n_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic [F-1:0]       frame_w;

    assign frame_w = {CTRL_WORD, bus.dds_data};

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            hold_q       <= '0;
            shift_q      <= '0;
            dac_sclk_q   <= 1'b0;
            dac_din_q    <= 1'b0;
            dac_cs_n_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            dac_sclk_q   <= dac_sclk_d;
            dac_din_q    <= dac_din_d;
            dac_cs_n_q   <= dac_cs_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        dac_sclk_d   = dac_sclk_q;
        dac_din_d    = dac_din_q;
        dac_cs_n_d   = dac_cs_n_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                div_d      = '0;
                bit_d      = '0;
                hold_d     = '0;
                dac_sclk_d = 1'b0;
                dac_din_d  = 1'b0;
                dac_cs_n_d = 1'b1;
                busy_d     = 1'b0;
                if (bus.dds_data_en) begin
                    shift_d    = frame_w;
                    dac_din_d  = frame_w[F-1];
                    dac_cs_n_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!dac_sclk_q) begin
                        dac_sclk_d = 1'b1;
                        bit_d      = bit_q + 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        // cs_n rises on the same edge as the last fall: zero hold by design
                        dac_sclk_d = 1'b0;
                        dac_cs_n_d = 1'b1;
                        dac_din_d  = 1'b0;
                        state_d    = HOLD;
                    end else begin
                        dac_sclk_d = 1'b0;
                        shift_d    = {shift_q[F-2:0], shift_q[F-1]};
                        dac_din_d  = shift_q[F-2];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d       = '0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.dac_sclk   = dac_sclk_q;
    assign bus.dac_din    = dac_din_q;
    assign bus.dac_cs_n   = dac_cs_n_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: two instances (default timing with CTRL_WORD=4'b0100,
// and HALF_DIV=HOLD_CYC=1) share one randomized sample stream.
module tb_dac_spi_tx;
    localparam int F   = 16;
    localparam int HD0 = 2;
    localparam int HC0 = 2;
    localparam int HD1 = 1;
    localparam int HC1 = 1;
    localparam logic [3:0] CW0 = 4'b0100;
    localparam logic [3:0] CW1 = 4'b0000;

    typedef struct {
        logic [15:0] word;
        int          cap;
    } exp_t;

    logic sclk;
    logic rst;
    int   edge_cnt;
    int   cmp_cnt;
    int   fail_cnt;

    exp_t q0[$];
    exp_t q1[$];
    int   next_free [2];

    logic        prev_sclk [2];
    logic        prev_din  [2];
    logic        prev_cs   [2];
    logic        prev_done [2];
    int          since_din [2];
    int          since_rise[2];
    int          since_cs  [2];
    int          low_cnt   [2];
    int          nbits     [2];
    int          cap_edge  [2];
    logic [15:0] word      [2];

    dac_spi_tx_if #(.DATA_BIT(12)) bus0 ();
    dac_spi_tx_if #(.DATA_BIT(12)) bus1 ();

    dac_spi_tx #(
        .DATA_BIT(12), .CTRL_BITS(4), .CTRL_WORD(CW0), .HALF_DIV(HD0), .HOLD_CYC(HC0)
    ) dut0 (
        .sclk(sclk),
        .rst (rst),
        .bus (bus0)
    );

    dac_spi_tx #(
        .DATA_BIT(12), .CTRL_BITS(4), .CTRL_WORD(CW1), .HALF_DIV(HD1), .HOLD_CYC(HC1)
    ) dut1 (
        .sclk(sclk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial edge_cnt = 0;
    always @(posedge sclk) edge_cnt <= edge_cnt + 1;

    function automatic int hdOf(input int u);
        return (u == 0) ? HD0 : HD1;
    endfunction

    function automatic int hcOf(input int u);
        return (u == 0) ? HC0 : HC1;
    endfunction

    task automatic checkOutput(input string name, input int u, input logic [31:0] act,
                               input logic [31:0] expv);
        cmp_cnt++;
        if (act !== expv) begin
            fail_cnt++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h", name, u, act, expv);
        end
    endtask

    // Reference model: a frame is captured whenever the driver is free, and it stays
    // busy for a whole frame period; anything offered in between is dropped.
    task automatic applyStimulus(input logic en, input logic [11:0] data,
                                 input bit data_is_edge = 1'b0);
        logic [11:0] d;
        exp_t        e;
        @(negedge sclk);
        d = data_is_edge ? 12'(edge_cnt) : data;
        bus0.dds_data    = d;
        bus0.dds_data_en = en;
        bus1.dds_data    = d;
        bus1.dds_data_en = en;
        if (en) begin
            for (int u = 0; u < 2; u++) begin
                if (edge_cnt >= next_free[u]) begin
                    e.word = {(u == 0) ? CW0 : CW1, d};
                    e.cap  = edge_cnt;
                    if (u == 0) q0.push_back(e);
                    else        q1.push_back(e);
                    next_free[u] = edge_cnt + 2 * F * hdOf(u) + hcOf(u) + 1;
                end
            end
        end
    endtask

    task automatic releaseReset();
        @(posedge sclk);
        #1;
        rst = 1'b0;
        next_free[0] = edge_cnt;
        next_free[1] = edge_cnt;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_sclk", 0, bus0.dac_sclk, 0);
        checkOutput("rst_din", 0, bus0.dac_din, 0);
        checkOutput("rst_cs_n", 0, bus0.dac_cs_n, 1);
        checkOutput("rst_busy", 0, bus0.busy, 0);
        checkOutput("rst_done", 0, bus0.frame_done, 0);
        checkOutput("rst_sclk", 1, bus1.dac_sclk, 0);
        checkOutput("rst_din", 1, bus1.dac_din, 0);
        checkOutput("rst_cs_n", 1, bus1.dac_cs_n, 1);
        checkOutput("rst_busy", 1, bus1.busy, 0);
        checkOutput("rst_done", 1, bus1.frame_done, 0);
    endtask

    task automatic monReset(input int u);
        prev_sclk[u]  = 1'b0;
        prev_din[u]   = 1'b0;
        prev_cs[u]    = 1'b1;
        prev_done[u]  = 1'b0;
        since_din[u]  = 1000;
        since_rise[u] = 1000;
        since_cs[u]   = 1 << 20;
        low_cnt[u]    = 0;
        nbits[u]      = 0;
        cap_edge[u]   = -1;
        word[u]       = '0;
    endtask

    task automatic observeDut(input int u, input logic sclk_v, input logic din_v,
                              input logic cs_v, input logic busy_v, input logic done_v);
        int   h;
        logic changed;
        logic rise;
        exp_t e;
        h       = hdOf(u);
        changed = (din_v !== prev_din[u]);
        rise    = sclk_v && !prev_sclk[u];
        since_din[u]  = changed ? 0 : since_din[u] + 1;
        since_rise[u] = rise ? 0 : since_rise[u] + 1;
        since_cs[u]   = since_cs[u] + 1;

        checkOutput("sclk_with_cs_high", u, sclk_v & cs_v, 0);
        checkOutput("done_width", u, done_v & prev_done[u], 0);
        checkOutput("busy_in_frame", u, !cs_v & !busy_v, 0);

        if (!cs_v && prev_cs[u]) begin
            cap_edge[u] = edge_cnt - 1;
            low_cnt[u]  = 0;
            nbits[u]    = 0;
            word[u]     = '0;
        end
        if (!cs_v) low_cnt[u]++;
        if (changed) checkOutput("din_hold_after_rise", u, since_rise[u] >= h, 1);
        if (rise) begin
            checkOutput("din_setup_before_rise", u, since_din[u] >= h, 1);
            word[u] = {word[u][14:0], din_v};
            nbits[u]++;
        end

        if (cs_v && !prev_cs[u]) begin
            since_cs[u] = 0;
            if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                checkOutput("unexpected_frame", u, 1, 0);
            end else begin
                e = (u == 0) ? q0.pop_front() : q1.pop_front();
                checkOutput("frame_word", u, word[u], e.word);
                checkOutput("capture_edge", u, cap_edge[u], e.cap);
                checkOutput("rise_count", u, nbits[u], F);
                checkOutput("cs_low_cycles", u, low_cnt[u], 2 * F * h);
            end
        end
        if (done_v) checkOutput("done_after_cs", u, since_cs[u], hcOf(u));

        prev_sclk[u] = sclk_v;
        prev_din[u]  = din_v;
        prev_cs[u]   = cs_v;
        prev_done[u] = done_v;
    endtask

    always @(negedge sclk) begin
        if (rst) begin
            monReset(0);
            monReset(1);
        end else begin
            observeDut(0, bus0.dac_sclk, bus0.dac_din, bus0.dac_cs_n, bus0.busy, bus0.frame_done);
            observeDut(1, bus1.dac_sclk, bus1.dac_din, bus1.dac_cs_n, bus1.busy, bus1.frame_done);
        end
    end

    initial begin
        cmp_cnt          = 0;
        fail_cnt         = 0;
        rst              = 1'b1;
        bus0.dds_data    = '0;
        bus0.dds_data_en = 1'b0;
        bus1.dds_data    = '0;
        bus1.dds_data_en = 1'b0;
        next_free[0]     = 0;
        next_free[1]     = 0;
        monReset(0);
        monReset(1);

        repeat (3) @(posedge sclk);
        #1;
        checkResetValues();
        releaseReset();

        // Single frame right after reset release
        applyStimulus(1'b1, 12'hA5C);
        repeat (80) applyStimulus(1'b0, 12'h000);

        // Continuous stream with data equal to the edge index
        repeat (210) applyStimulus(1'b1, 12'h000, 1'b1);
        repeat (80) applyStimulus(1'b0, 12'h000);

        // Enable drops at edge 20 of a frame
        repeat (21) applyStimulus(1'b1, 12'h3C7);
        repeat (100) applyStimulus(1'b0, 12'h000);

        // Reset between rise 7 and fall 7 of dut0
        applyStimulus(1'b1, 12'h9B1);
        repeat (26) applyStimulus(1'b0, 12'h000);
        @(posedge sclk);
        #1;
        checkOutput("pre_reset_sclk_high", 0, bus0.dac_sclk, 1);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        checkResetValues();
        repeat (2) @(posedge sclk);
        releaseReset();
        applyStimulus(1'b1, 12'h5E3);
        repeat (80) applyStimulus(1'b0, 12'h000);

        // All-ones then all-zeros data
        applyStimulus(1'b1, 12'hFFF);
        repeat (80) applyStimulus(1'b0, 12'h000);
        applyStimulus(1'b1, 12'h000);
        repeat (80) applyStimulus(1'b0, 12'h000);

        // Randomized enable and data
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, 12'($urandom));
        end

        for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) begin
            applyStimulus(1'b0, 12'h000);
        end
        repeat (5) applyStimulus(1'b0, 12'h000);
        checkOutput("drain_empty", 0, q0.size(), 0);
        checkOutput("drain_empty", 1, q1.size(), 0);
        checkOutput("idle_cs_n", 0, bus0.dac_cs_n, 1);
        checkOutput("idle_cs_n", 1, bus1.dac_cs_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule
